// File: rtl/taxi_eth_frame_gen_pkg.sv
// Shared types and helpers for the 10G MAC test-frame generator.
// Holds the FSM state encoding, header geometry and tail-beat keep helper.
package taxi_eth_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    localparam int ETH_HDR_LEN = 14;
    localparam int MIN_LEN     = 60;

    function automatic logic [7:0] last_keep(input logic [15:0] len);
        logic [2:0] r;
        r = len[2:0];
        return (r == 3'd0) ? 8'hFF : 8'(8'h1 << r) - 8'h1;
    endfunction

endpackage

// File: rtl/taxi_eth_frame_gen_cpl_track.sv
// Completion tracker: outstanding-frame count and in-order tid check.
// A completion with nothing outstanding is an error and never underflows.
module taxi_eth_frame_gen_cpl_track #(
    parameter int ID_W    = 8,
    parameter int MAX_OUT = 16,
    parameter int CNT_W   = 32,
    parameter int OUT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             tx_done_i,
    input  logic             cpl_valid_i,
    input  logic [ID_W-1:0]  cpl_tid_i,
    output logic [OUT_W-1:0] outstanding_o,
    output logic [CNT_W-1:0] cpl_count_o,
    output logic [CNT_W-1:0] cpl_err_o
);

    logic [OUT_W-1:0] out_q;
    logic [ID_W-1:0]  exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] err_q;
    logic             has_out;
    logic             dec;
    logic             bad;

    always_comb begin
        has_out = (out_q != '0);
        dec     = cpl_valid_i && has_out;
        bad     = cpl_valid_i && (!has_out || (cpl_tid_i != exp_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
            exp_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            if (tx_done_i && !dec) begin
                out_q <= out_q + OUT_W'(1);
            end else if (!tx_done_i && dec) begin
                out_q <= out_q - OUT_W'(1);
            end
            if (clr_i) begin
                exp_q <= '0;
                cnt_q <= '0;
                err_q <= '0;
            end else if (cpl_valid_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (bad) begin
                    // resync on the received tag so one gap is one error
                    exp_q <= cpl_tid_i + ID_W'(1);
                    if (err_q != '1) begin
                        err_q <= err_q + CNT_W'(1);
                    end
                end else begin
                    exp_q <= exp_q + ID_W'(1);
                end
            end
        end
    end

    assign outstanding_o = out_q;
    assign cpl_count_o   = cnt_q;
    assign cpl_err_o     = err_q;

endmodule

// File: rtl/taxi_eth_axis_frame_gen.sv
// Ethernet test-frame source for the MAC tx path: header + counting payload,
// tid-tagged frames, bounded by in-flight completions.
module taxi_eth_axis_frame_gen
    import taxi_eth_frame_gen_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int ID_W    = 8,
    parameter int USER_W  = 1,
    parameter int MAX_OUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                         tx_clk,
    input  logic                         tx_rst,
    input  logic                         cfg_enable,
    input  logic [15:0]                  cfg_frame_len,
    input  logic [CNT_W-1:0]             cfg_frame_count,
    input  logic [7:0]                   cfg_gap_cycles,
    input  logic [47:0]                  cfg_eth_dst,
    input  logic [47:0]                  cfg_eth_src,
    input  logic [15:0]                  cfg_eth_type,
    input  logic                         start,
    output logic [DATA_W-1:0]            m_axis_tx_tdata,
    output logic [KEEP_W-1:0]            m_axis_tx_tkeep,
    output logic                         m_axis_tx_tvalid,
    input  logic                         m_axis_tx_tready,
    output logic                         m_axis_tx_tlast,
    output logic [USER_W-1:0]            m_axis_tx_tuser,
    output logic [ID_W-1:0]              m_axis_tx_tid,
    input  logic                         s_axis_tx_cpl_tvalid,
    input  logic [ID_W-1:0]              s_axis_tx_cpl_tid,
    output logic                         s_axis_tx_cpl_tready,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             stat_frames_sent,
    output logic [CNT_W-1:0]             stat_cpl_count,
    output logic [CNT_W-1:0]             stat_cpl_err,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);

    if (DATA_W != 64) begin : g_bad_width
        $fatal(1, "taxi_eth_axis_frame_gen: only DATA_W=64 supported");
    end
    if (MAX_OUT < 1 || MAX_OUT > (2 ** ID_W) - 1) begin : g_bad_out
        $fatal(1, "taxi_eth_axis_frame_gen: MAX_OUT out of range");
    end

    function automatic logic [63:0] beat_data(
        input logic [12:0] beat,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] typ,
        input logic [7:0]  idx
    );
        logic [63:0] d;
        logic [15:0] n;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            n = {beat, 3'b000} + 16'(i);
            if (n < 16'd6) begin
                d[8*i +: 8] = 8'(dst >> (8 * (5 - int'(n))));
            end else if (n < 16'd12) begin
                d[8*i +: 8] = 8'(src >> (8 * (11 - int'(n))));
            end else if (n == 16'd12) begin
                d[8*i +: 8] = typ[15:8];
            end else if (n == 16'd13) begin
                d[8*i +: 8] = typ[7:0];
            end else begin
                d[8*i +: 8] = 8'(n - 16'(ETH_HDR_LEN)) + idx;
            end
        end
        return d;
    endfunction

    state_t             state_q;
    logic [12:0]        beat_q;
    logic [12:0]        last_beat_q;
    logic [7:0]         keep_last_q;
    logic [47:0]        dst_q;
    logic [47:0]        src_q;
    logic [15:0]        type_q;
    logic [CNT_W-1:0]   count_q;
    logic [7:0]         gap_q;
    logic [7:0]         gap_cnt_q;
    logic [CNT_W-1:0]   idx_q;
    logic [DATA_W-1:0]  tdata_q;
    logic [KEEP_W-1:0]  tkeep_q;
    logic               tlast_q;
    logic               tvalid_q;
    logic [ID_W-1:0]    tid_q;
    logic               done_q;
    logic               run_q;

    logic               fire;
    logic               last_fire;
    logic [CNT_W-1:0]   idx_inc;
    logic [12:0]        beat_inc;
    logic               more_now;
    logic               more_next;
    logic               start_ok;
    logic               tail_go;
    logic               gap_go;
    logic               load_first;
    logic [ID_W-1:0]    first_tag;
    logic [15:0]        len_in;

    always_comb begin
        fire      = tvalid_q && m_axis_tx_tready;
        last_fire = fire && tlast_q;
        idx_inc   = idx_q + CNT_W'(1);
        beat_inc  = beat_q + 13'd1;
        more_now  = cfg_enable && (count_q == '0 || idx_q < count_q);
        more_next = cfg_enable && (count_q == '0 || idx_inc < count_q);
        start_ok  = (state_q == ST_IDLE) && (outstanding == '0)
                    && start && cfg_enable;
        // back-to-back launch must leave room for the frame just closed
        tail_go   = last_fire && (gap_q == 8'd0) && more_next
                    && (int'(outstanding) < MAX_OUT - 1);
        gap_go    = (state_q == ST_GAP) && (gap_cnt_q == 8'd0) && more_now
                    && (int'(outstanding) < MAX_OUT);
        load_first = start_ok || tail_go || gap_go;
        first_tag = '0;
        if (tail_go) begin
            first_tag = idx_inc[ID_W-1:0];
        end else if (gap_go) begin
            first_tag = idx_q[ID_W-1:0];
        end
        len_in = (cfg_frame_len < 16'(MIN_LEN)) ? 16'(MIN_LEN)
                                                 : cfg_frame_len;
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            last_beat_q <= '0;
            keep_last_q <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            tid_q       <= '0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_q && outstanding == '0) begin
                        done_q <= 1'b1;
                    end
                    if (start_ok) begin
                        done_q <= 1'b0;
                        run_q  <= 1'b1;
                        idx_q  <= '0;
                    end
                end
                ST_HDR0, ST_HDR1, ST_PAYLOAD: begin
                    if (last_fire) begin
                        tvalid_q  <= 1'b0;
                        tlast_q   <= 1'b0;
                        idx_q     <= idx_inc;
                        state_q   <= ST_GAP;
                        gap_cnt_q <= (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;
                    end else if (fire) begin
                        beat_q  <= beat_inc;
                        tdata_q <= beat_data(beat_inc, dst_q, src_q,
                                             type_q, idx_q[7:0]);
                        tlast_q <= (beat_inc == last_beat_q);
                        tkeep_q <= (beat_inc == last_beat_q) ? keep_last_q
                                                             : 8'hFF;
                        state_q <= (state_q == ST_HDR0) ? ST_HDR1
                                                        : ST_PAYLOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != 8'd0) begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end else if (!more_now) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (load_first) begin
                state_q     <= ST_HDR0;
                beat_q      <= '0;
                last_beat_q <= 13'((len_in - 16'd1) >> 3);
                keep_last_q <= last_keep(len_in);
                dst_q       <= cfg_eth_dst;
                src_q       <= cfg_eth_src;
                type_q      <= cfg_eth_type;
                count_q     <= cfg_frame_count;
                gap_q       <= cfg_gap_cycles;
                tdata_q     <= beat_data(13'd0, cfg_eth_dst, cfg_eth_src,
                                         cfg_eth_type, 8'd0);
                tkeep_q     <= 8'hFF;
                tlast_q     <= 1'b0;
                tvalid_q    <= 1'b1;
                tid_q       <= first_tag;
            end
        end
    end

    taxi_eth_frame_gen_cpl_track #(
        .ID_W    (ID_W),
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_cpl (
        .clk_i         (tx_clk),
        .rst_i         (tx_rst),
        .clr_i         (start_ok),
        .tx_done_i     (last_fire),
        .cpl_valid_i   (s_axis_tx_cpl_tvalid),
        .cpl_tid_i     (s_axis_tx_cpl_tid),
        .outstanding_o (outstanding),
        .cpl_count_o   (stat_cpl_count),
        .cpl_err_o     (stat_cpl_err)
    );

    assign m_axis_tx_tdata      = tdata_q;
    assign m_axis_tx_tkeep      = tkeep_q;
    assign m_axis_tx_tvalid     = tvalid_q;
    assign m_axis_tx_tlast      = tlast_q;
    assign m_axis_tx_tuser      = '0;
    assign m_axis_tx_tid        = tid_q;
    assign s_axis_tx_cpl_tready = 1'b1;
    assign busy                 = (state_q != ST_IDLE) || (outstanding != '0);
    assign done                 = done_q;
    assign stat_frames_sent     = idx_q;

endmodule

// File: tb/tb_taxi_eth_axis_frame_gen.sv
// Directed bench for taxi_eth_axis_frame_gen with MAX_OUT=2.
// Frames are captured per handshake and checked against a byte-level model.
module tb_taxi_eth_axis_frame_gen;

    localparam int MAX_OUT = 2;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic        cfg_enable;
    logic [15:0] cfg_frame_len;
    logic [31:0] cfg_frame_count;
    logic [7:0]  cfg_gap_cycles;
    logic [47:0] cfg_eth_dst;
    logic [47:0] cfg_eth_src;
    logic [15:0] cfg_eth_type;
    logic        start;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [0:0]  tuser;
    logic [7:0]  tid;
    logic        cpl_valid;
    logic [7:0]  cpl_tid;
    logic        cpl_ready;
    logic        busy;
    logic        done;
    logic [31:0] sent;
    logic [31:0] cpl_cnt;
    logic [31:0] cpl_err;
    logic [1:0]  outst;

    always #5 tx_clk = ~tx_clk;

    taxi_eth_axis_frame_gen #(
        .MAX_OUT (MAX_OUT)
    ) dut (
        .tx_clk               (tx_clk),
        .tx_rst               (tx_rst),
        .cfg_enable           (cfg_enable),
        .cfg_frame_len        (cfg_frame_len),
        .cfg_frame_count      (cfg_frame_count),
        .cfg_gap_cycles       (cfg_gap_cycles),
        .cfg_eth_dst          (cfg_eth_dst),
        .cfg_eth_src          (cfg_eth_src),
        .cfg_eth_type         (cfg_eth_type),
        .start                (start),
        .m_axis_tx_tdata      (tdata),
        .m_axis_tx_tkeep      (tkeep),
        .m_axis_tx_tvalid     (tvalid),
        .m_axis_tx_tready     (tready),
        .m_axis_tx_tlast      (tlast),
        .m_axis_tx_tuser      (tuser),
        .m_axis_tx_tid        (tid),
        .s_axis_tx_cpl_tvalid (cpl_valid),
        .s_axis_tx_cpl_tid    (cpl_tid),
        .s_axis_tx_cpl_tready (cpl_ready),
        .busy                 (busy),
        .done                 (done),
        .stat_frames_sent     (sent),
        .stat_cpl_count       (cpl_cnt),
        .stat_cpl_err         (cpl_err),
        .outstanding          (outst)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [7:0]  t;
        int          c;
    } beat_t;

    beat_t      cap[$];
    logic [7:0] man_q[$];
    logic [7:0] auto_q[$];
    int         man_rd;
    int         cyc;
    int         drops;
    bit         in_frame;
    bit         rnd_ready;
    bit         auto_cpl;
    int         n_chk;
    int         n_err;
    int         base;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready, completion driver and handshake capture, away from posedge
    always @(negedge tx_clk) begin
        cyc++;
        tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cpl_valid = 1'b0;
        cpl_tid = 8'd0;
        if (man_rd < man_q.size()) begin
            cpl_valid = 1'b1;
            cpl_tid = man_q[man_rd];
            man_rd++;
        end else if (auto_q.size() > 0) begin
            cpl_valid = 1'b1;
            cpl_tid = auto_q.pop_front();
        end
        if (tx_rst) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && !tvalid) drops++;
            if (tvalid && tready) begin
                cap.push_back('{d: tdata, k: tkeep, l: tlast, t: tid, c: cyc});
                in_frame = !tlast;
                if (tlast && auto_cpl) auto_q.push_back(tid);
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int n, input int idx);
        if (n < 6) return cfg_eth_dst[47-8*n -: 8];
        if (n < 12) return cfg_eth_src[47-8*(n-6) -: 8];
        if (n == 12) return cfg_eth_type[15:8];
        if (n == 13) return cfg_eth_type[7:0];
        return 8'((n - 14 + idx) % 256);
    endfunction

    task automatic check_frames(input string tag, input int b0,
                                input int nfr, input int len);
        int L, nb, bad, p;
        logic [7:0]  ek;
        logic [63:0] ed, m;
        L = (len < 60) ? 60 : len;
        nb = (L + 7) / 8;
        bad = 0;
        chk({tag, "_beats"}, 64'(cap.size() - b0), 64'(nfr * nb));
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < nb; b++) begin
                p = b0 + f * nb + b;
                if (p >= cap.size()) begin
                    bad++;
                    continue;
                end
                ek = 8'hFF;
                if (b == nb - 1 && L % 8 != 0) ek = 8'((1 << (L % 8)) - 1);
                for (int i = 0; i < 8; i++) begin
                    ed[8*i +: 8] = exp_byte(8 * b + i, f);
                    m[8*i +: 8] = ek[i] ? 8'hFF : 8'h00;
                end
                if ((cap[p].d & m) != (ed & m) || cap[p].k != ek
                    || cap[p].l != (b == nb - 1) || cap[p].t != 8'(f))
                    bad++;
            end
        end
        chk({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge tx_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && sent != 32'(n); i++) begin
            @(posedge tx_clk);
            #1;
        end
        chk({tag, "_sent"}, 64'(sent), 64'(n));
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge tx_clk);
            #1;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && cap.size() < base + n; i++) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic setup(input int len, input int count, input int gap);
        cfg_frame_len = 16'(len);
        cfg_frame_count = 32'(count);
        cfg_gap_cycles = 8'(gap);
        base = cap.size();
    endtask

    initial begin
        tx_rst = 1'b1;
        start = 1'b0;
        cfg_enable = 1'b1;
        cfg_frame_len = 16'd60;
        cfg_frame_count = 32'd1;
        cfg_gap_cycles = 8'd0;
        cfg_eth_dst = 48'h010203040506;
        cfg_eth_src = 48'h0A0B0C0D0E0F;
        cfg_eth_type = 16'h0800;
        repeat (3) @(posedge tx_clk);
        #1 tx_rst = 1'b0;
        @(posedge tx_clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sent", 64'(sent), 64'd0);
        chk("rst_outst", 64'(outst), 64'd0);

        // single minimum frame, manual completion
        setup(60, 1, 0);
        pulse_start();
        wait_sent("t1", 1, 100);
        chk("t1_outst_pend", 64'(outst), 64'd1);
        chk("t1_busy_pend", 64'(busy), 64'd1);
        check_frames("t1", base, 1, 60);
        if (cap.size() >= base + 8) begin
            chk("t1_beat0", 64'(cap[base].d[47:0]), 64'h060504030201);
            chk("t1_keep", 64'(cap[base+7].k), 64'h0F);
            chk("t1_tid", 64'(cap[base].t), 64'd0);
        end else begin
            chk("t1_cap", 64'(cap.size() - base), 64'd8);
        end
        man_q.push_back(8'd0);
        wait_done("t1", 100);
        chk("t1_outst", 64'(outst), 64'd0);
        chk("t1_err", 64'(cpl_err), 64'd0);
        chk("t1_cplcnt", 64'(cpl_cnt), 64'd1);

        // three back-to-back frames
        auto_cpl = 1'b1;
        setup(64, 3, 0);
        pulse_start();
        wait_done("t2", 500);
        check_frames("t2", base, 3, 64);
        if (cap.size() >= base + 24)
            chk("t2_b2b", 64'(cap[base+23].c - cap[base].c), 64'd23);
        chk("t2_sent", 64'(sent), 64'd3);
        chk("t2_cplcnt", 64'(cpl_cnt), 64'd3);
        chk("t2_err", 64'(cpl_err), 64'd0);

        // random backpressure with a gap
        rnd_ready = 1'b1;
        setup(100, 2, 3);
        pulse_start();
        wait_done("t3", 1000);
        check_frames("t3", base, 2, 100);
        chk("t3_drops", 64'(drops), 64'd0);
        rnd_ready = 1'b0;

        // short length clamps to the minimum
        setup(20, 1, 0);
        pulse_start();
        wait_done("t3c", 300);
        check_frames("t3c", base, 1, 20);

        // outstanding limit stalls the generator
        auto_cpl = 1'b0;
        setup(60, 0, 0);
        pulse_start();
        repeat (60) @(posedge tx_clk);
        #1;
        chk("t4_sent_stall", 64'(sent), 64'd2);
        chk("t4_outst", 64'(outst), 64'd2);
        chk("t4_tvalid", 64'(tvalid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        pulse_start();
        repeat (3) @(posedge tx_clk);
        #1;
        chk("t4_start_ign", 64'(sent), 64'd2);
        man_q.push_back(8'd0);
        wait_sent("t4_third", 3, 100);
        repeat (20) @(posedge tx_clk);
        #1;
        chk("t4_sent_stall2", 64'(sent), 64'd3);
        cfg_enable = 1'b0;
        man_q.push_back(8'd1);
        man_q.push_back(8'd2);
        wait_done("t4", 200);
        chk("t4_err", 64'(cpl_err), 64'd0);
        chk("t4_busy_end", 64'(busy), 64'd0);
        check_frames("t4", base, 3, 60);
        cfg_enable = 1'b1;

        // out-of-order completion tag
        setup(60, 3, 0);
        pulse_start();
        wait_sent("t5a", 2, 100);
        man_q.push_back(8'd0);
        wait_sent("t5b", 3, 100);
        repeat (5) @(posedge tx_clk);
        #1;
        man_q.push_back(8'd2);
        repeat (5) @(posedge tx_clk);
        #1;
        chk("t5_err_skip", 64'(cpl_err), 64'd1);
        chk("t5_outst", 64'(outst), 64'd1);
        man_q.push_back(8'd3);
        wait_done("t5", 100);
        chk("t5_err_resync", 64'(cpl_err), 64'd1);
        chk("t5_cplcnt", 64'(cpl_cnt), 64'd3);

        // stop mid-frame, config change mid-frame ignored
        auto_cpl = 1'b1;
        setup(200, 0, 0);
        pulse_start();
        wait_beats(3);
        cfg_enable = 1'b0;
        cfg_frame_len = 16'd60;
        wait_done("t6", 500);
        check_frames("t6", base, 1, 200);
        chk("t6_sent", 64'(sent), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        cfg_enable = 1'b1;

        // reset in the middle of a frame
        setup(200, 0, 0);
        pulse_start();
        wait_beats(3);
        tx_rst = 1'b1;
        @(posedge tx_clk);
        #1 tx_rst = 1'b0;
        chk("t7_tvalid", 64'(tvalid), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_sent", 64'(sent), 64'd0);
        chk("t7_cplcnt", 64'(cpl_cnt), 64'd0);
        chk("t7_outst", 64'(outst), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
